// File: rtl/freq_ctrl_pkg.sv
// Shared types and helpers for the frequency step controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package freq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SWEEP_UP = 2'd1,
        SWEEP_DN = 2'd2
    } sweep_state_t;

    // Clamp v into [lo, hi]; callers size the result down to the incr width.
    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> debounced level -> registered press pulse.
// Latency: a clean rising edge gives the press pulse DEBOUNCE_CYC+2 edges after the raw change.
// Backpressure: none; the pulse is one cycle wide and fires only on a debounced 0->1.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one and pulse on a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else if (sync2 == level) begin
            cnt   <= '0;
            press <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
            press <= ~level;
        end else begin
            cnt   <= cnt + 1'b1;
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/freq_step_ctrl.sv
// Turns debounced up/down buttons, a direct load, and (FREQ_SWEEP_EN) a triangle sweep into incr.
// Latency: incr, at_min, at_max and step are registered; clean button -> incr in DEBOUNCE_CYC+3 edges.
// Backpressure: none; load wins over sweep, and sweep wins over buttons, every cycle.
module freq_step_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int DEBOUNCE_CYC = 16,
    parameter int INCR_MIN     = 1,
    parameter int INCR_MAX     = 64,
    parameter int INCR_RST     = 1,
    parameter int SWEEP_DWELL  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sweep,
    output logic [WIDTH-1:0] incr,
    output logic             at_min,
    output logic             at_max,
    output logic             step
);
    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(INCR_MIN);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(INCR_MAX);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(INCR_MIN);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(INCR_MAX);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(INCR_RST);

    logic             up_press;
    logic             dn_press;
    logic [WIDTH:0]   incr_x;
    logic [WIDTH:0]   up_x;
    logic [WIDTH:0]   dn_x;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] man_nxt;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] incr_nxt;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .press (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dn),
        .press (dn_press)
    );

    // Saturating +/-1 one bit wider than incr so the limits can never wrap.
    always_comb begin
        incr_x = {1'b0, incr};
        up_x   = (incr_x >= MAX_X) ? MAX_X : incr_x + 1'b1;
        dn_x   = (incr_x <= MIN_X) ? MIN_X : incr_x - 1'b1;
        up_val = WIDTH'(up_x);
        dn_val = WIDTH'(dn_x);
        load_clamped = WIDTH'(clamp(32'(load_val), 32'(INCR_MIN), 32'(INCR_MAX)));
    end

    // Manual stepping: a lone press moves incr, simultaneous presses cancel.
    always_comb begin
        man_nxt = incr;
        if (up_press && !dn_press) begin
            man_nxt = up_val;
        end else if (dn_press && !up_press) begin
            man_nxt = dn_val;
        end
    end

`ifdef FREQ_SWEEP_EN
    localparam int DW = $clog2(SWEEP_DWELL + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SWEEP_DWELL - 1);

    sweep_state_t  state;
    sweep_state_t  state_nxt;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_nxt;

    // Next incr and sweep state: load first, then the sweep dwell timer, then buttons in IDLE.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        incr_nxt  = incr;
        if (load) begin
            incr_nxt  = load_clamped;
            dwell_nxt = '0;
            if (!sweep) begin
                state_nxt = IDLE;
            end else if (state == IDLE) begin
                state_nxt = SWEEP_UP;
            end
        end else begin
            case (state)
                IDLE: begin
                    incr_nxt = man_nxt;
                    if (sweep) begin
                        state_nxt = SWEEP_UP;
                        dwell_nxt = '0;
                    end
                end
                SWEEP_UP, SWEEP_DN: begin
                    if (!sweep) begin
                        state_nxt = IDLE;
                        dwell_nxt = '0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell_nxt = '0;
                        if (state == SWEEP_UP) begin
                            incr_nxt = up_val;
                            if (up_val == MAX_W) state_nxt = SWEEP_DN;
                        end else begin
                            incr_nxt = dn_val;
                            if (dn_val == MIN_W) state_nxt = SWEEP_UP;
                        end
                    end else begin
                        dwell_nxt = dwell + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sweep state and dwell timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dwell <= '0;
        end else begin
            state <= state_nxt;
            dwell <= dwell_nxt;
        end
    end
`else
    localparam int unused_dwell = SWEEP_DWELL;
    logic unused_sweep;
    assign unused_sweep = sweep;

    // Manual-only build: load over buttons.
    always_comb begin
        incr_nxt = load ? load_clamped : man_nxt;
    end
`endif

    // Output registers; limit flags and step are decoded from the value being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            incr   <= RST_W;
            at_min <= (RST_W == MIN_W);
            at_max <= (RST_W == MAX_W);
            step   <= 1'b0;
        end else begin
            incr   <= incr_nxt;
            at_min <= (incr_nxt == MIN_W);
            at_max <= (incr_nxt == MAX_W);
            step   <= (incr_nxt != incr);
        end
    end

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Directed bench for freq_step_ctrl with DEBOUNCE_CYC=4, INCR_MAX=8, SWEEP_DWELL=4.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a; sweep section is built only with FREQ_SWEEP_EN.
module tb_freq_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_dn;
    logic       load;
    logic [8:0] load_val;
    logic       sweep;
    logic [8:0] incr;
    logic       at_min;
    logic       at_max;
    logic       step;
    logic       saw;

    int checks = 0;
    int errors = 0;

    freq_step_ctrl #(
        .WIDTH        (9),
        .DEBOUNCE_CYC (4),
        .INCR_MIN     (1),
        .INCR_MAX     (8),
        .INCR_RST     (1),
        .SWEEP_DWELL  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .load     (load),
        .load_val (load_val),
        .sweep    (sweep),
        .incr     (incr),
        .at_min   (at_min),
        .at_max   (at_max),
        .step     (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [8:0] v);
        load     = 1'b1;
        load_val = v;
        tick(1);
        load     = 1'b0;
    endtask

    // Clean press and release; reports whether step was ever seen.
    task automatic press(input logic up, input logic dn, output logic seen);
        seen   = 1'b0;
        btn_up = up;
        btn_dn = dn;
        repeat (12) begin
            tick(1);
            if (step) seen = 1'b1;
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (12) begin
            tick(1);
            if (step) seen = 1'b1;
        end
    endtask

    initial begin
        logic [8:0] seq [10];
        seq = '{9'd7, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd2};

        rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
        load = 1'b0; load_val = '0; sweep = 1'b0;
        tick(2);
        check("rst_incr",   32'(incr),   32'd1);
        check("rst_at_min", 32'(at_min), 32'd1);
        check("rst_at_max", 32'(at_max), 32'd0);
        check("rst_step",   32'(step),   32'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_incr", 32'(incr), 32'd1);

        // Clean press: incr moves on the 7th edge after the raw rise.
        btn_up = 1'b1;
        tick(6);
        check("lat_edge6_incr", 32'(incr), 32'd1);
        tick(1);
        check("lat_edge7_incr", 32'(incr), 32'd2);
        check("lat_edge7_step", 32'(step), 32'd1);
        tick(1);
        check("lat_step_width", 32'(step), 32'd0);
        saw = 1'b0;
        repeat (50) begin
            tick(1);
            if (step) saw = 1'b1;
        end
        check("hold_incr", 32'(incr), 32'd2);
        check("hold_no_repeat", 32'(saw), 32'd0);
        btn_up = 1'b0;
        tick(12);
        check("release_silent", 32'(incr), 32'd2);

        // Bounce every 2 cycles never reaches the debounce threshold.
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            repeat (2) begin
                tick(1);
                if (step) saw = 1'b1;
            end
        end
        btn_up = 1'b0;
        repeat (12) begin
            tick(1);
            if (step) saw = 1'b1;
        end
        check("bounce_incr", 32'(incr), 32'd2);
        check("bounce_step", 32'(saw),  32'd0);

        // Step up to the ceiling and past it.
        do_load(9'd1);
        check("load1_incr", 32'(incr), 32'd1);
        check("load1_step", 32'(step), 32'd1);
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 1'b0, saw);
            check($sformatf("up_press%0d", i), 32'(incr), 32'(i + 2));
        end
        check("ceil_at_max", 32'(at_max), 32'd1);
        check("ceil_at_min", 32'(at_min), 32'd0);
        press(1'b1, 1'b0, saw);
        check("sat_incr", 32'(incr), 32'd8);
        check("sat_step", 32'(saw),  32'd0);
        press(1'b1, 1'b1, saw);
        check("both_incr", 32'(incr), 32'd8);
        check("both_step", 32'(saw),  32'd0);
        press(1'b0, 1'b1, saw);
        check("dn_incr",   32'(incr),   32'd7);
        check("dn_at_max", 32'(at_max), 32'd0);

        // Load clamping and priority over a button pulse.
        do_load(9'd0);
        check("load0_incr",   32'(incr),   32'd1);
        check("load0_at_min", 32'(at_min), 32'd1);
        do_load(9'd200);
        check("load200_incr",   32'(incr),   32'd8);
        check("load200_at_max", 32'(at_max), 32'd1);
        do_load(9'd8);
        check("load_same_step", 32'(step), 32'd0);
        do_load(9'd3);
        btn_up = 1'b1;
        tick(6);
        load = 1'b1; load_val = 9'd5;
        tick(1);
        load = 1'b0;
        check("load_vs_up_incr", 32'(incr), 32'd5);
        tick(20);
        btn_up = 1'b0;
        tick(12);
        check("load_vs_up_after", 32'(incr), 32'd5);

`ifdef FREQ_SWEEP_EN
        // Triangle sweep from 6, one step per 4 cycles.
        do_load(9'd6);
        sweep = 1'b1;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            logic [8:0] prev;
            prev = (k == 0) ? 9'd6 : seq[k-1];
            tick(3);
            check($sformatf("sweep_hold%0d", k), 32'(incr), 32'(prev));
            tick(1);
            check($sformatf("sweep_step%0d", k), 32'(incr), 32'(seq[k]));
        end
        tick(2);
        rst = 1'b1;
        #1;
        check("sweep_rst_incr",   32'(incr),   32'd1);
        check("sweep_rst_at_min", 32'(at_min), 32'd1);
        sweep = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        check("sweep_rst_idle", 32'(incr), 32'd1);
        sweep = 1'b1;
        tick(1);
        tick(3);
        check("resweep_hold", 32'(incr), 32'd1);
        tick(1);
        check("resweep_step", 32'(incr), 32'd2);
        sweep = 1'b0;
        tick(1);
        tick(8);
        check("sweep_off_held", 32'(incr), 32'd2);
`else
        // Manual-only build: sweep input has no effect.
        sweep = 1'b1;
        tick(20);
        check("sweep_ignored", 32'(incr), 32'd5);
        sweep = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_again_incr", 32'(incr), 32'd1);
        tick(2);
        rst = 1'b0;
        tick(2);
        check("rst_again_hold", 32'(incr), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
